// File: rtl/time_set_ctl.sv
// Calendar/clock setting controller. It snapshots the live BCD counters, lets the user
// edit one field at a time with inc/dec buttons (with auto-repeat), and on commit
// presents the edited date/time together with a one-cycle load pulse.
module time_set_ctl #(
  parameter int unsigned DIP_WIDTH = 6,
  parameter int unsigned HOLD_CYC  = 25000000,
  parameter int unsigned RPT_CYC   = 5000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIP_WIDTH-1:0] DIP,
  input  logic                 btn_set,
  input  logic                 btn_cancel,
  input  logic                 btn_field,
  input  logic                 btn_inc,
  input  logic                 btn_dec,
  input  logic [3:0]           cur_sec_unit,
  input  logic [3:0]           cur_sec_tens,
  input  logic [3:0]           cur_min_unit,
  input  logic [3:0]           cur_min_tens,
  input  logic [3:0]           cur_hour_unit,
  input  logic [3:0]           cur_hour_tens,
  input  logic [3:0]           cur_day_unit,
  input  logic [3:0]           cur_day_tens,
  input  logic [3:0]           cur_month_unit,
  input  logic [3:0]           cur_month_tens,
  input  logic [3:0]           cur_year_unit,
  input  logic [3:0]           cur_year_tens,
  input  logic [3:0]           cur_year_hund,
  input  logic [3:0]           cur_year_thou,
  output logic [3:0]           set_sec_unit,
  output logic [3:0]           set_sec_tens,
  output logic [3:0]           set_min_unit,
  output logic [3:0]           set_min_tens,
  output logic [3:0]           set_hour_unit,
  output logic [3:0]           set_hour_tens,
  output logic [3:0]           set_day_unit,
  output logic [3:0]           set_day_tens,
  output logic [3:0]           set_month_unit,
  output logic [3:0]           set_month_tens,
  output logic [3:0]           set_year_unit,
  output logic [3:0]           set_year_tens,
  output logic [3:0]           set_year_hund,
  output logic [3:0]           set_year_thou,
  output logic                 load,
  output logic                 editing,
  output logic                 field_idx
);

  localparam int unsigned CntMax = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  // Digit slots of the edit buffer
  localparam int unsigned IdxSecU = 0;
  localparam int unsigned IdxSecT = 1;
  localparam int unsigned IdxMinU = 2;
  localparam int unsigned IdxMinT = 3;
  localparam int unsigned IdxHrU  = 4;
  localparam int unsigned IdxHrT  = 5;
  localparam int unsigned IdxDayU = 6;
  localparam int unsigned IdxDayT = 7;
  localparam int unsigned IdxMonU = 8;
  localparam int unsigned IdxMonT = 9;
  localparam int unsigned IdxYrU  = 10;
  localparam int unsigned IdxYrT  = 11;
  localparam int unsigned IdxYrH  = 12;
  localparam int unsigned IdxYrK  = 13;

  typedef enum logic [1:0] {StIdle, StEdit, StCommit} state_e;
  typedef enum logic [2:0] {FldSec, FldMin, FldHour, FldDay, FldMonth, FldYear} field_e;

  state_e          state_q, state_d;
  field_e          fld;
  logic            fidx_q, fidx_d;
  logic            load_q, load_d;
  logic            edit_q, edit_d;
  logic            prev_inc_q, prev_dec_q;
  logic            rep_inc_q, rep_inc_d, rep_dec_q, rep_dec_d;
  logic [CntW-1:0] cnt_inc_q, cnt_inc_d, cnt_dec_q, cnt_dec_d;
  logic            step_inc, step_dec;
  logic [3:0]      dig_q [14];
  logic [3:0]      dig_d [14];
  logic [7:0]      pair;
  logic [7:0]      dim_n;
  logic [15:0]     year_n;
  logic            unused_dip;

  // Only the low four DIP bits select a page
  assign unused_dip = ^DIP[DIP_WIDTH-1:4];

  function automatic logic [7:0] bcd_val(input logic [3:0] t, input logic [3:0] u);
    return 8'(t) * 8'd10 + 8'(u);
  endfunction

  function automatic logic [7:0] to_bcd(input logic [7:0] v);
    return {4'(v / 8'd10), 4'(v % 8'd10)};
  endfunction

  // Two-digit wrap step; anything outside lo..hi (or non-BCD) snaps to lo
  function automatic logic [7:0] step2(input logic [3:0] t, input logic [3:0] u,
                                       input logic up, input logic [7:0] lo,
                                       input logic [7:0] hi);
    logic [7:0] v;
    logic [7:0] n;
    v = bcd_val(t, u);
    if (t > 4'd9 || u > 4'd9 || v < lo || v > hi) begin
      n = lo;
    end else if (up) begin
      n = (v == hi) ? lo : v + 8'd1;
    end else begin
      n = (v == lo) ? hi : v - 8'd1;
    end
    return to_bcd(n);
  endfunction

  // Four-digit BCD year step with ripple carry/borrow, wrapping 0000..9999
  function automatic logic [15:0] step_year(input logic [15:0] y, input logic up);
    logic [15:0] r;
    logic        c;
    r = '0;
    c = 1'b1;
    if (y[3:0] <= 4'd9 && y[7:4] <= 4'd9 && y[11:8] <= 4'd9 && y[15:12] <= 4'd9) begin
      r = y;
      for (int i = 0; i < 4; i++) begin
        if (c) begin
          if (up) begin
            if (r[i*4 +: 4] == 4'd9) begin
              r[i*4 +: 4] = 4'd0;
            end else begin
              r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
              c = 1'b0;
            end
          end else begin
            if (r[i*4 +: 4] == 4'd0) begin
              r[i*4 +: 4] = 4'd9;
            end else begin
              r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
              c = 1'b0;
            end
          end
        end
      end
    end
    return r;
  endfunction

  // 10 == 2 (mod 4), so a two-digit BCD pair is divisible by 4 iff 2*tens+unit is
  function automatic logic is_leap(input logic [15:0] y);
    logic [1:0] s;
    if (y[7:0] != 8'h00) s = {y[4], 1'b0} + y[1:0];
    else                 s = {y[12], 1'b0} + y[9:8];
    return s == 2'b00;
  endfunction

  function automatic logic [7:0] days_in_month(input logic [3:0] mt, input logic [3:0] mu,
                                               input logic leap);
    logic [7:0] d;
    case (bcd_val(mt, mu))
      8'd2:                   d = leap ? 8'd29 : 8'd28;
      8'd4, 8'd6, 8'd9, 8'd11: d = 8'd30;
      default:                d = 8'd31;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] clamp_day(input logic [3:0] dt, input logic [3:0] du,
                                           input logic [7:0] dim);
    logic [7:0] r;
    r = {dt, du};
    if (dt <= 4'd9 && du <= 4'd9 && bcd_val(dt, du) > dim) r = to_bcd(dim);
    return r;
  endfunction

  // Press-and-hold step generator: returns {step, rep_next, cnt_next}
  function automatic logic [CntW+1:0] rpt_next(input logic active, input logic btn,
                                               input logic prev, input logic rep,
                                               input logic [CntW-1:0] cnt);
    logic            step;
    logic            rep_n;
    logic [CntW-1:0] cnt_n;
    step  = 1'b0;
    rep_n = rep;
    cnt_n = cnt;
    if (!active || !btn) begin
      rep_n = 1'b0;
      cnt_n = '0;
    end else if (!prev) begin
      step  = 1'b1;
      rep_n = 1'b0;
      cnt_n = CntW'(1);
    end else if (cnt != '0) begin
      if ((!rep && cnt == CntW'(HOLD_CYC)) || (rep && cnt == CntW'(RPT_CYC))) begin
        step  = 1'b1;
        rep_n = 1'b1;
        cnt_n = CntW'(1);
      end else begin
        cnt_n = cnt + CntW'(1);
      end
    end
    return {step, rep_n, cnt_n};
  endfunction

  // Auto-repeat step generation for both buttons; pressing both blocks either
  always_comb begin
    {step_inc, rep_inc_d, cnt_inc_d} =
        rpt_next(state_q == StEdit && !btn_dec, btn_inc, prev_inc_q, rep_inc_q, cnt_inc_q);
    {step_dec, rep_dec_d, cnt_dec_d} =
        rpt_next(state_q == StEdit && !btn_inc, btn_dec, prev_dec_q, rep_dec_q, cnt_dec_q);
  end

  // Page/field decode, higher DIP rows take priority
  always_comb begin
    fld = FldSec;
    if (DIP[3])                fld = FldYear;
    else if (DIP[2])           fld = fidx_q ? FldDay : FldMonth;
    else if (DIP[1:0] == 2'b11) fld = fidx_q ? FldMin : FldHour;
    else if (DIP[1:0] == 2'b10) fld = FldHour;
    else if (DIP[1:0] == 2'b01) fld = FldSec;
    else                       fld = fidx_q ? FldSec : FldMin;
  end

  // FSM next state, field index and edit-buffer updates
  always_comb begin
    state_d = state_q;
    fidx_d  = fidx_q;
    dig_d   = dig_q;
    pair    = '0;
    dim_n   = '0;
    year_n  = '0;
    case (state_q)
      StIdle: begin
        if (btn_set) begin
          state_d        = StEdit;
          fidx_d         = 1'b0;
          dig_d[IdxSecU] = cur_sec_unit;
          dig_d[IdxSecT] = cur_sec_tens;
          dig_d[IdxMinU] = cur_min_unit;
          dig_d[IdxMinT] = cur_min_tens;
          dig_d[IdxHrU]  = cur_hour_unit;
          dig_d[IdxHrT]  = cur_hour_tens;
          dig_d[IdxDayU] = cur_day_unit;
          dig_d[IdxDayT] = cur_day_tens;
          dig_d[IdxMonU] = cur_month_unit;
          dig_d[IdxMonT] = cur_month_tens;
          dig_d[IdxYrU]  = cur_year_unit;
          dig_d[IdxYrT]  = cur_year_tens;
          dig_d[IdxYrH]  = cur_year_hund;
          dig_d[IdxYrK]  = cur_year_thou;
        end
      end
      StEdit: begin
        if (btn_set) begin
          state_d = StCommit;
        end else if (btn_cancel) begin
          state_d = StIdle;
        end else begin
          if (btn_field) fidx_d = ~fidx_q;
          if (step_inc || step_dec) begin
            case (fld)
              FldSec: begin
                pair = step2(dig_q[IdxSecT], dig_q[IdxSecU], step_inc, 8'd0, 8'd59);
                dig_d[IdxSecT] = pair[7:4];
                dig_d[IdxSecU] = pair[3:0];
              end
              FldMin: begin
                pair = step2(dig_q[IdxMinT], dig_q[IdxMinU], step_inc, 8'd0, 8'd59);
                dig_d[IdxMinT] = pair[7:4];
                dig_d[IdxMinU] = pair[3:0];
              end
              FldHour: begin
                pair = step2(dig_q[IdxHrT], dig_q[IdxHrU], step_inc, 8'd0, 8'd23);
                dig_d[IdxHrT] = pair[7:4];
                dig_d[IdxHrU] = pair[3:0];
              end
              FldDay: begin
                dim_n = days_in_month(dig_q[IdxMonT], dig_q[IdxMonU],
                    is_leap({dig_q[IdxYrK], dig_q[IdxYrH], dig_q[IdxYrT], dig_q[IdxYrU]}));
                pair = step2(dig_q[IdxDayT], dig_q[IdxDayU], step_inc, 8'd1, dim_n);
                dig_d[IdxDayT] = pair[7:4];
                dig_d[IdxDayU] = pair[3:0];
              end
              FldMonth: begin
                pair = step2(dig_q[IdxMonT], dig_q[IdxMonU], step_inc, 8'd1, 8'd12);
                dig_d[IdxMonT] = pair[7:4];
                dig_d[IdxMonU] = pair[3:0];
                dim_n = days_in_month(pair[7:4], pair[3:0],
                    is_leap({dig_q[IdxYrK], dig_q[IdxYrH], dig_q[IdxYrT], dig_q[IdxYrU]}));
                pair = clamp_day(dig_q[IdxDayT], dig_q[IdxDayU], dim_n);
                dig_d[IdxDayT] = pair[7:4];
                dig_d[IdxDayU] = pair[3:0];
              end
              FldYear: begin
                year_n = step_year({dig_q[IdxYrK], dig_q[IdxYrH], dig_q[IdxYrT], dig_q[IdxYrU]},
                                   step_inc);
                dig_d[IdxYrK] = year_n[15:12];
                dig_d[IdxYrH] = year_n[11:8];
                dig_d[IdxYrT] = year_n[7:4];
                dig_d[IdxYrU] = year_n[3:0];
                dim_n = days_in_month(dig_q[IdxMonT], dig_q[IdxMonU], is_leap(year_n));
                pair = clamp_day(dig_q[IdxDayT], dig_q[IdxDayU], dim_n);
                dig_d[IdxDayT] = pair[7:4];
                dig_d[IdxDayU] = pair[3:0];
              end
              default: ;
            endcase
          end
        end
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    load_d = (state_d == StCommit);
    edit_d = (state_d != StIdle);
  end

  // State, edit buffer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fidx_q     <= 1'b0;
      load_q     <= 1'b0;
      edit_q     <= 1'b0;
      prev_inc_q <= 1'b0;
      prev_dec_q <= 1'b0;
      rep_inc_q  <= 1'b0;
      rep_dec_q  <= 1'b0;
      cnt_inc_q  <= '0;
      cnt_dec_q  <= '0;
      for (int i = 0; i < 14; i++) dig_q[i] <= 4'd0;
      dig_q[IdxDayU] <= 4'd1;
      dig_q[IdxMonU] <= 4'd1;
      dig_q[IdxYrK]  <= 4'd2;
    end else begin
      state_q    <= state_d;
      fidx_q     <= fidx_d;
      load_q     <= load_d;
      edit_q     <= edit_d;
      prev_inc_q <= btn_inc;
      prev_dec_q <= btn_dec;
      rep_inc_q  <= rep_inc_d;
      rep_dec_q  <= rep_dec_d;
      cnt_inc_q  <= cnt_inc_d;
      cnt_dec_q  <= cnt_dec_d;
      dig_q      <= dig_d;
    end
  end

  assign set_sec_unit   = dig_q[IdxSecU];
  assign set_sec_tens   = dig_q[IdxSecT];
  assign set_min_unit   = dig_q[IdxMinU];
  assign set_min_tens   = dig_q[IdxMinT];
  assign set_hour_unit  = dig_q[IdxHrU];
  assign set_hour_tens  = dig_q[IdxHrT];
  assign set_day_unit   = dig_q[IdxDayU];
  assign set_day_tens   = dig_q[IdxDayT];
  assign set_month_unit = dig_q[IdxMonU];
  assign set_month_tens = dig_q[IdxMonT];
  assign set_year_unit  = dig_q[IdxYrU];
  assign set_year_tens  = dig_q[IdxYrT];
  assign set_year_hund  = dig_q[IdxYrH];
  assign set_year_thou  = dig_q[IdxYrK];
  assign load           = load_q;
  assign editing        = edit_q;
  assign field_idx      = fidx_q;

endmodule

// File: tb/tb_time_set_ctl.sv
// Bench for time_set_ctl: directed scenarios plus random button traffic, all checked
// cycle by cycle against a calendar-level reference model.
module tb_time_set_ctl;

  localparam int Hold = 4;
  localparam int Rpt  = 2;
  localparam int FSec = 0, FMin = 1, FHour = 2, FDay = 3, FMon = 4, FYear = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  dip = '0;
  logic        btn_set = 1'b0, btn_cancel = 1'b0, btn_field = 1'b0;
  logic        btn_inc = 1'b0, btn_dec = 1'b0;
  logic [55:0] cur_v = '0;
  logic [55:0] set_v;
  logic        load, editing, field_idx;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: 0 idle, 1 edit, 2 commit; fields kept as plain integers
  int m_st = 0;
  int m_sec = 0, m_min = 0, m_hour = 0, m_day = 1, m_mon = 1, m_year = 2000;
  bit m_fidx = 0, m_load = 0;
  int age_inc = -1, age_dec = -1;
  bit prev_inc = 0, prev_dec = 0;
  int c_s = 0, c_mi = 0, c_h = 0, c_d = 1, c_mo = 1, c_y = 2000;

  always #5 clk = ~clk;

  time_set_ctl #(.DIP_WIDTH(6), .HOLD_CYC(Hold), .RPT_CYC(Rpt)) dut (
    .clk            (clk),
    .rst            (rst),
    .DIP            (dip),
    .btn_set        (btn_set),
    .btn_cancel     (btn_cancel),
    .btn_field      (btn_field),
    .btn_inc        (btn_inc),
    .btn_dec        (btn_dec),
    .cur_sec_unit   (cur_v[3:0]),
    .cur_sec_tens   (cur_v[7:4]),
    .cur_min_unit   (cur_v[11:8]),
    .cur_min_tens   (cur_v[15:12]),
    .cur_hour_unit  (cur_v[19:16]),
    .cur_hour_tens  (cur_v[23:20]),
    .cur_day_unit   (cur_v[27:24]),
    .cur_day_tens   (cur_v[31:28]),
    .cur_month_unit (cur_v[35:32]),
    .cur_month_tens (cur_v[39:36]),
    .cur_year_unit  (cur_v[43:40]),
    .cur_year_tens  (cur_v[47:44]),
    .cur_year_hund  (cur_v[51:48]),
    .cur_year_thou  (cur_v[55:52]),
    .set_sec_unit   (set_v[3:0]),
    .set_sec_tens   (set_v[7:4]),
    .set_min_unit   (set_v[11:8]),
    .set_min_tens   (set_v[15:12]),
    .set_hour_unit  (set_v[19:16]),
    .set_hour_tens  (set_v[23:20]),
    .set_day_unit   (set_v[27:24]),
    .set_day_tens   (set_v[31:28]),
    .set_month_unit (set_v[35:32]),
    .set_month_tens (set_v[39:36]),
    .set_year_unit  (set_v[43:40]),
    .set_year_tens  (set_v[47:44]),
    .set_year_hund  (set_v[51:48]),
    .set_year_thou  (set_v[55:52]),
    .load           (load),
    .editing        (editing),
    .field_idx      (field_idx)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [55:0] pack(input int s, input int mi, input int h, input int d,
                                       input int mo, input int y);
    logic [55:0] v;
    v[3:0]   = 4'(s % 10);          v[7:4]   = 4'(s / 10);
    v[11:8]  = 4'(mi % 10);         v[15:12] = 4'(mi / 10);
    v[19:16] = 4'(h % 10);          v[23:20] = 4'(h / 10);
    v[27:24] = 4'(d % 10);          v[31:28] = 4'(d / 10);
    v[35:32] = 4'(mo % 10);         v[39:36] = 4'(mo / 10);
    v[43:40] = 4'(y % 10);          v[47:44] = 4'((y / 10) % 10);
    v[51:48] = 4'((y / 100) % 10);  v[55:52] = 4'(y / 1000);
    return v;
  endfunction

  function automatic int dim(input int mo, input int y);
    bit leap;
    leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    if (mo == 2) return leap ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  function automatic int wrap(input int v, input int lo, input int hi, input bit up);
    if (v < lo || v > hi) return lo;
    if (up) return (v == hi) ? lo : v + 1;
    return (v == lo) ? hi : v - 1;
  endfunction

  function automatic int field_of(input logic [5:0] d, input bit idx);
    if (d[3]) return FYear;
    if (d[2]) return idx ? FDay : FMon;
    if (d[1:0] == 2'b11) return idx ? FMin : FHour;
    if (d[1:0] == 2'b10) return FHour;
    if (d[1:0] == 2'b01) return FSec;
    return idx ? FSec : FMin;
  endfunction

  // Cycles a button has been held since its press inside edit mode; -1 when not tracking
  function automatic int next_age(input bit in_edit, input bit b, input bit other,
                                  input bit prev, input int age);
    if (!in_edit || !b || other) return -1;
    if (!prev) return 0;
    if (age >= 0) return age + 1;
    return -1;
  endfunction

  function automatic bit is_step(input int age);
    return (age == 0) || (age >= Hold && (age - Hold) % Rpt == 0);
  endfunction

  task automatic model_step();
    bit in_edit, s_inc, s_dec;
    int fld;
    in_edit = (m_st == 1);
    age_inc = next_age(in_edit, btn_inc, btn_dec, prev_inc, age_inc);
    age_dec = next_age(in_edit, btn_dec, btn_inc, prev_dec, age_dec);
    s_inc = is_step(age_inc);
    s_dec = is_step(age_dec);
    prev_inc = btn_inc;
    prev_dec = btn_dec;
    if (rst) begin
      m_st = 0; m_fidx = 0; age_inc = -1; age_dec = -1; prev_inc = 0; prev_dec = 0;
      m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_mon = 1; m_year = 2000;
    end else if (m_st == 0) begin
      if (btn_set) begin
        m_st = 1; m_fidx = 0;
        m_sec = c_s; m_min = c_mi; m_hour = c_h; m_day = c_d; m_mon = c_mo; m_year = c_y;
      end
    end else if (m_st == 1) begin
      if (btn_set) m_st = 2;
      else if (btn_cancel) m_st = 0;
      else begin
        fld = field_of(dip, m_fidx);
        if (btn_field) m_fidx = ~m_fidx;
        if (s_inc || s_dec) begin
          case (fld)
            FSec:  m_sec  = wrap(m_sec, 0, 59, s_inc);
            FMin:  m_min  = wrap(m_min, 0, 59, s_inc);
            FHour: m_hour = wrap(m_hour, 0, 23, s_inc);
            FDay:  m_day  = wrap(m_day, 1, dim(m_mon, m_year), s_inc);
            FMon: begin
              m_mon = wrap(m_mon, 1, 12, s_inc);
              if (m_day > dim(m_mon, m_year)) m_day = dim(m_mon, m_year);
            end
            default: begin
              m_year = wrap(m_year, 0, 9999, s_inc);
              if (m_day > dim(m_mon, m_year)) m_day = dim(m_mon, m_year);
            end
          endcase
        end
      end
    end else begin
      m_st = 0;
    end
    m_load = (m_st == 2);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("set_digits", set_v, pack(m_sec, m_min, m_hour, m_day, m_mon, m_year));
    check("load", load, m_load);
    check("editing", editing, m_st != 0);
    check("field_idx", field_idx, m_fidx);
  endtask

  task automatic set_cur(input int s, input int mi, input int h, input int d, input int mo,
                         input int y);
    c_s = s; c_mi = mi; c_h = h; c_d = d; c_mo = mo; c_y = y;
    cur_v = pack(s, mi, h, d, mo, y);
  endtask

  task automatic press_set();
    btn_set = 1'b1; tick(); btn_set = 1'b0;
  endtask

  task automatic press_cancel();
    btn_cancel = 1'b1; tick(); btn_cancel = 1'b0;
  endtask

  task automatic press_field();
    btn_field = 1'b1; tick(); btn_field = 1'b0;
  endtask

  task automatic tap(input bit up);
    if (up) btn_inc = 1'b1;
    else    btn_dec = 1'b1;
    tick();
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    tick();
  endtask

  task automatic directed(input string tag, input int s, input int mi, input int h,
                          input int d, input int mo, input int y, input logic [5:0] pg,
                          input bit idx1, input bit up, input logic [55:0] exp);
    set_cur(s, mi, h, d, mo, y);
    dip = pg;
    press_set();
    if (idx1) press_field();
    tap(up);
    check(tag, set_v, exp);
    press_cancel();
  endtask

  initial begin
    int years [4];
    int feb   [4];
    years = '{2023, 2024, 2100, 2000};
    feb   = '{28, 29, 28, 29};

    set_cur(12, 34, 5, 6, 7, 2011);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset_digits", set_v, pack(0, 0, 0, 1, 1, 2000));
    check("reset_load", load, 1'b0);
    check("reset_editing", editing, 1'b0);

    // Minute edit does not carry into hour
    set_cur(58, 59, 23, 28, 2, 2023);
    dip = 6'b000000;
    press_set();
    tap(1'b1);
    press_set();
    check("commit_load", load, 1'b1);
    check("commit_value", set_v, pack(58, 0, 23, 28, 2, 2023));
    tick();
    check("commit_load_clear", load, 1'b0);

    // January 31 -> February clamps to the year's February length
    for (int i = 0; i < 4; i++)
      directed("feb_clamp", 0, 0, 0, 31, 1, years[i], 6'b000100, 1'b0, 1'b1,
               pack(0, 0, 0, feb[i], 2, years[i]));

    directed("hour_inc_wrap", 0, 0, 23, 1, 1, 2000, 6'b000010, 1'b0, 1'b1,
             pack(0, 0, 0, 1, 1, 2000));
    directed("hour_dec_wrap", 0, 0, 0, 1, 1, 2000, 6'b000010, 1'b0, 1'b0,
             pack(0, 0, 23, 1, 1, 2000));
    directed("month_dec_wrap", 0, 0, 0, 15, 1, 2001, 6'b000100, 1'b0, 1'b0,
             pack(0, 0, 0, 15, 12, 2001));
    directed("year_inc_wrap", 0, 0, 0, 15, 1, 9999, 6'b001000, 1'b0, 1'b1,
             pack(0, 0, 0, 15, 1, 0));
    directed("day_dec_wrap", 0, 0, 0, 1, 4, 2001, 6'b000100, 1'b1, 1'b0,
             pack(0, 0, 0, 30, 4, 2001));
    directed("sec_force_min", 75, 0, 0, 1, 1, 2000, 6'b000001, 1'b0, 1'b1,
             pack(0, 0, 0, 1, 1, 2000));
    directed("page0_idx1_sec", 10, 20, 3, 1, 1, 2000, 6'b000000, 1'b1, 1'b1,
             pack(11, 20, 3, 1, 1, 2000));
    directed("page3_idx1_min", 10, 20, 3, 1, 1, 2000, 6'b000011, 1'b1, 1'b0,
             pack(10, 19, 3, 1, 1, 2000));
    directed("upper_dip_ignored", 0, 0, 0, 9, 5, 2000, 6'b110100, 1'b0, 1'b1,
             pack(0, 0, 0, 9, 6, 2000));
    directed("year_leap_clamp", 0, 0, 0, 29, 2, 2024, 6'b001000, 1'b0, 1'b1,
             pack(0, 0, 0, 28, 2, 2025));

    // Auto-repeat: steps at held cycles 0, 4, 6, 8
    set_cur(0, 30, 12, 10, 6, 2010);
    dip = 6'b000001;
    press_set();
    btn_inc = 1'b1;
    repeat (10) tick();
    btn_inc = 1'b0;
    tick();
    check("auto_repeat", set_v, pack(4, 30, 12, 10, 6, 2010));
    btn_inc = 1'b1;
    btn_dec = 1'b1;
    repeat (6) tick();
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    tick();
    check("inc_dec_both", set_v, pack(4, 30, 12, 10, 6, 2010));
    press_cancel();

    // Cancel keeps the edited value but never loads
    set_cur(5, 1, 1, 1, 1, 2000);
    dip = 6'b000001;
    press_set();
    tap(1'b1);
    press_cancel();
    check("cancel_editing", editing, 1'b0);
    check("cancel_load", load, 1'b0);
    check("cancel_keep", set_v, pack(6, 1, 1, 1, 1, 2000));

    press_set();
    tap(1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_edit_reset", set_v, pack(0, 0, 0, 1, 1, 2000));
    check("mid_edit_reset_editing", editing, 1'b0);

    press_set();
    btn_set = 1'b1;
    btn_cancel = 1'b1;
    tick();
    btn_set = 1'b0;
    btn_cancel = 1'b0;
    check("set_beats_cancel", load, 1'b1);
    tick();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      btn_set    = ($urandom_range(0, 15) == 0);
      btn_cancel = ($urandom_range(0, 29) == 0);
      btn_field  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) btn_inc = ~btn_inc;
      if ($urandom_range(0, 7) == 0) btn_dec = ~btn_dec;
      if ($urandom_range(0, 40) == 0) dip = 6'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 3) == 0)
        set_cur(int'($urandom_range(0, 59)), int'($urandom_range(0, 59)),
                int'($urandom_range(0, 23)), int'($urandom_range(1, 31)),
                int'($urandom_range(1, 12)),
                ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 9999))
                                            : int'($urandom_range(0, 99)) * 100);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
